// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state, width helpers and output round/saturate for the FIR MAC
package fir_pkg;
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   function automatic int ptr_width(input int taps);
      return $clog2(taps);
   endfunction
   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int coef_w, input int data_w);
      logic signed [63:0] r, hi;
      r = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      return r > hi ? hi : r < -hi - 64'sd1 ? -hi - 64'sd1 : r;
   endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: TAPS x COEF_W coefficient register file, gated write, async read by tap
module fir_coef_bank import fir_pkg::*; #(
   parameter int COEF_W = 16,
   parameter int TAPS = 32,
   parameter int AW = ptr_width(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_i,
   input  logic                     ready_i,
   input  logic [AW-1:0]            waddr_i,
   input  logic signed [COEF_W-1:0] wdata_i,
   input  logic [AW-1:0]            raddr_i,
   output logic signed [COEF_W-1:0] rdata_o
);
   logic signed [COEF_W-1:0] coef_q [TAPS];
   always_ff @(posedge clk)
      if (!rst) coef_q <= '{default: '0};
      else if (we_i && ready_i) coef_q[waddr_i] <= wdata_i;
   assign rdata_o = coef_q[raddr_i];
endmodule

// File: rtl/fir_filter_mac.sv
// fir_filter_mac: programmable FIR with one time-multiplexed MAC, bypass and overrun flag
module fir_filter_mac import fir_pkg::*; #(
   parameter int DATA_W = 12,
   parameter int COEF_W = 16,
   parameter int TAPS = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            f_s,
   input  logic signed [DATA_W-1:0]        din,
   input  logic                            bypass,
   input  logic                            coef_we,
   input  logic [ptr_width(TAPS)-1:0]      coef_addr,
   input  logic signed [COEF_W-1:0]        coef_data,
   input  logic                            ovr_clr,
   output logic signed [DATA_W-1:0]        dout,
   output logic                            dout_valid,
   output logic                            busy,
   output logic                            coef_ready,
   output logic                            overrun
);
   localparam int AW = ptr_width(TAPS);
   localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
   localparam int PW = DATA_W + COEF_W;
   state_t st_q;
   logic fs_q, ev, vld_q, ovr_q;
   logic [AW-1:0] np_q, np_n, k_q, ra;
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [DATA_W-1:0] res_q, res_d, dout_q;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [COEF_W-1:0] c;
   logic signed [PW-1:0] prod;
   fir_coef_bank #(.COEF_W(COEF_W), .TAPS(TAPS), .AW(AW)) u_bank (
      .clk(clk), .rst(rst), .we_i(coef_we), .ready_i(coef_ready), .waddr_i(coef_addr),
      .wdata_i(coef_data), .raddr_i(k_q), .rdata_o(c)
   );
   assign ev = f_s & ~fs_q;
   assign busy = st_q != IDLE;
   assign coef_ready = !busy;
   assign np_n = np_q + AW'(1);
   assign ra = np_q - k_q;
   assign prod = PW'(x_q[ra]) * PW'(c);
   assign acc_d = acc_q + ACC_W'(prod);
   assign res_d = bypass ? x_q[np_q] : DATA_W'(sat_round(64'(acc_q), COEF_W, DATA_W));
   // OUT spends two cycles: k_q==0 registers the rounded result, then it is published
   always_ff @(posedge clk)
      if (!rst) begin
         st_q <= IDLE;
         fs_q <= 1'b0;
         np_q <= '0;
         k_q <= '0;
         acc_q <= '0;
         res_q <= '0;
         dout_q <= '0;
         vld_q <= 1'b0;
         ovr_q <= 1'b0;
         x_q <= '{default: '0};
      end else begin
         fs_q <= f_s;
         vld_q <= 1'b0;
         ovr_q <= (ev && busy) || (ovr_q && !ovr_clr);
         case (st_q)
            IDLE: if (ev) begin
               x_q[np_n] <= din;
               np_q <= np_n;
               acc_q <= '0;
               k_q <= '0;
               st_q <= MAC;
            end
            MAC: begin
               acc_q <= acc_d;
               k_q <= k_q + AW'(1);
               if (k_q == AW'(TAPS - 1)) st_q <= OUT;
            end
            OUT: if (k_q == '0) begin
               res_q <= res_d;
               k_q <= AW'(1);
            end else begin
               dout_q <= res_q;
               vld_q <= 1'b1;
               st_q <= IDLE;
            end
            default: st_q <= IDLE;
         endcase
      end
   assign dout = dout_q;
   assign dout_valid = vld_q;
   assign overrun = ovr_q;
endmodule

// File: tb/tb_fir_filter_mac.sv
// tb_fir_filter_mac: directed and random stimulus against a sum-of-products FIR model
module tb_fir_filter_mac;
   localparam int DW = 12, CW = 16, T = 32;
   logic clk = 1'b0, rst = 1'b0, f_s = 1'b0, bypass = 1'b0, coef_we = 1'b0, ovr_clr = 1'b0;
   logic signed [DW-1:0] din = '0;
   logic [4:0] coef_addr = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic signed [DW-1:0] dout;
   logic dout_valid, busy, coef_ready, overrun;
   int checks = 0, failures = 0;
   int coef [T];
   int hist [$];
   int e;
   logic seen;
   always #5 clk = ~clk;
   fir_filter_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(T)) dut (
      .clk(clk), .rst(rst), .f_s(f_s), .din(din), .bypass(bypass), .coef_we(coef_we),
      .coef_addr(coef_addr), .coef_data(coef_data), .ovr_clr(ovr_clr), .dout(dout),
      .dout_valid(dout_valid), .busy(busy), .coef_ready(coef_ready), .overrun(overrun)
   );
   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask
   function automatic longint fdiv(input longint n, input longint d);
      longint q = n / d;
      if (n % d != 0 && n < 0) q--;
      return q;
   endfunction
   function automatic int model();
      longint a = 0, r;
      for (int k = 0; k < T; k++) a += longint'(hist[k]) * longint'(coef[k]);
      r = fdiv(a + (longint'(1) << (CW - 2)), longint'(1) << (CW - 1));
      if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
      if (r < -(longint'(1) << (DW - 1))) r = -(longint'(1) << (DW - 1));
      return int'(r);
   endfunction
   task automatic model_clear();
      foreach (coef[i]) coef[i] = 0;
      hist.delete();
      repeat (T) hist.push_back(0);
   endtask
   function automatic int push(input int v, input bit byp);
      hist.push_front(v);
      void'(hist.pop_back());
      return byp ? v : model();
   endfunction
   task automatic wr(input int a, input int d);
      @(negedge clk);
      coef_we = 1'b1;
      coef_addr = 5'(a);
      coef_data = CW'(d);
      coef[a] = d;
      @(negedge clk);
      coef_we = 1'b0;
   endtask
   task automatic wrall(input int d);
      for (int i = 0; i < T; i++) wr(i, d);
   endtask
   task automatic start(input int v, input bit byp, output int want);
      @(negedge clk);
      f_s = 1'b1;
      din = DW'(v);
      bypass = byp;
      want = push(v, byp);
      @(negedge clk);
      f_s = 1'b0;
      chk("busy_after_capture", busy, 1);
      chk("coef_ready_low", coef_ready, 0);
   endtask
   task automatic finish(input int want, input int c0);
      int cyc = c0;
      while (!dout_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, 34);
      chk("dout", dout, want);
      @(negedge clk);
      chk("valid_one_cycle", dout_valid, 0);
      chk("idle_after", busy, 0);
   endtask
   task automatic sample(input int v, input bit byp);
      int w;
      start(v, byp, w);
      finish(w, 0);
   endtask
   initial begin
      model_clear();
      repeat (4) begin
         @(negedge clk);
         f_s = ~f_s;
      end
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_coef_ready", coef_ready, 1);
      @(negedge clk);
      f_s = 1'b0;
      rst = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= dout_valid;
      end
      chk("rst_no_pulse", seen, 0);
      wr(0, 16384);
      sample(1000, 0);
      chk("impulse_half", dout, 500);
      repeat (31) sample(0, 0);
      chk("impulse_tail", dout, 0);
      wr(0, 0);
      wr(3, 32767);
      sample(1000, 0);
      repeat (3) sample(0, 0);
      chk("tap3_order", dout, 1000);
      sample(0, 0);
      wrall(1024);
      repeat (32) sample(2000, 0);
      chk("avg_pos", dout, 2000);
      repeat (32) sample(-2048, 0);
      chk("avg_neg", dout, -2048);
      wrall(32767);
      repeat (32) sample(2047, 0);
      chk("sat_pos", dout, 2047);
      repeat (32) sample(-2048, 0);
      chk("sat_neg", dout, -2048);
      sample(-777, 1);
      chk("bypass", dout, -777);
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(3)) wr(int'($urandom_range(T - 1)), int'($urandom_range(65535)) - 32768);
         sample(int'($urandom_range(4095)) - 2048, $urandom_range(9) == 0);
      end
      wrall(0);
      @(negedge clk);
      coef_we = 1'b1;
      coef_addr = 5'd0;
      coef_data = 16'sd8192;
      coef[0] = 8192;
      f_s = 1'b1;
      din = 12'sd400;
      bypass = 1'b0;
      e = push(400, 0);
      @(negedge clk);
      coef_we = 1'b0;
      f_s = 1'b0;
      finish(e, 0);
      chk("write_with_sample", dout, 100);
      wr(0, 16384);
      start(300, 0, e);
      repeat (9) @(negedge clk);
      f_s = 1'b1;
      din = -12'sd1500;
      @(negedge clk);
      f_s = 1'b0;
      chk("overrun_set", overrun, 1);
      coef_we = 1'b1;
      coef_addr = 5'd0;
      coef_data = 16'sd5000;
      @(negedge clk);
      coef_we = 1'b0;
      finish(e, 11);
      chk("dropped_sample", dout, 150);
      chk("overrun_sticky", overrun, 1);
      sample(800, 0);
      chk("busy_write_ignored", dout, 400);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      chk("overrun_clear", overrun, 0);
      start(100, 0, e);
      repeat (9) @(negedge clk);
      f_s = 1'b1;
      ovr_clr = 1'b1;
      @(negedge clk);
      f_s = 1'b0;
      ovr_clr = 1'b0;
      chk("overrun_set_wins", overrun, 1);
      finish(e, 10);
      start(123, 0, e);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= dout_valid;
      end
      chk("abort_no_pulse", seen, 0);
      chk("abort_dout", dout, 0);
      chk("abort_busy", busy, 0);
      chk("abort_overrun", overrun, 0);
      sample(555, 0);
      chk("abort_coefs_cleared", dout, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
